// File: rtl/emg_uart_tx.sv
// Byte-stream UART transmitter: valid/ready FIFO front end feeding an 8N1 framer for uart_0 rxd.
// Define EMG_UART_TX_PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module emg_uart_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("emg_uart_tx: clock cycles per bit must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("emg_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

`ifdef EMG_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    logic parity;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic          pop;
    logic          bit_end;

    assign tx_ready = (fifo_level != LW'(FIFO_DEPTH));
    assign busy     = (state != S_IDLE) || (fifo_level != '0);
    assign bit_end  = (baud_cnt == '0);
    assign push     = tx_valid && tx_ready;
    // A pop starts a frame: from IDLE, or straight out of STOP so frames run back to back.
    assign pop      = (fifo_level != '0) && ((state == S_IDLE) || (state == S_STOP && bit_end));

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state    <= S_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef EMG_UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            baud_cnt <= bit_end ? CW'(DIV - 1) : baud_cnt - CW'(1);
            if (pop) begin
                shift <= mem[rd_ptr];
`ifdef EMG_UART_TX_PARITY_EN
                parity <= ^mem[rd_ptr];
`endif
            end
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        baud_cnt <= CW'(DIV - 1);
                        txd      <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef EMG_UART_TX_PARITY_EN
                            txd   <= parity;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef EMG_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            txd   <= 1'b0;
                            state <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
